// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the ID-stage hazard/sequencing controller and the pipeline.
// The master side is the pipeline (drives hazard inputs); the slave side is the controller.
interface pipe_stall_ctrl_if;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_RegisterRt;
   logic [4:0]  IFID_RegisterRs;
   logic [4:0]  IFID_RegisterRt;
   logic        IFID_MemWrite;
   logic        IFID_IsMulDiv;
   logic        IFID_UsesHiLo;
   logic        EX_BranchTaken;
   logic        PCWrite;
   logic        IFID_Write;
   logic        IDEX_Bubble;
   logic        IFID_Flush;
   logic        md_start;
   logic        md_busy;
   logic [15:0] stall_cycles;

   modport master (
      output IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
             IFID_MemWrite, IFID_IsMulDiv, IFID_UsesHiLo, EX_BranchTaken,
      input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, md_start, md_busy,
             stall_cycles
   );

   modport slave (
      input  IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
             IFID_MemWrite, IFID_IsMulDiv, IFID_UsesHiLo, EX_BranchTaken,
      output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, md_start, md_busy,
             stall_cycles
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ID-stage stall/flush controller: load-use interlock, taken-branch flush and
// multi-cycle mult/div issue tracking with HI/LO structural/data stalls.
module pipe_stall_ctrl #(
   parameter int unsigned MD_CYCLES = 32
) (
   input logic             clk,
   input logic             reset,
   pipe_stall_ctrl_if.slave ps
);

   localparam int unsigned CNT_W = 6;
   localparam int unsigned SC_W  = 16;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
   logic [SC_W-1:0]   stall_cycles_q, stall_cycles_d;

   logic load_use_c;
   logic md_hazard_c;
   logic stall_c;
   logic pc_write_c;
   logic ifid_write_c;
   logic idex_bubble_c;
   logic ifid_flush_c;
   logic md_start_c;
   logic md_busy_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         md_cnt_q       <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         md_cnt_q       <= md_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   // Hazard detection, output priority (flush > stall > pass) and next state
   always_comb begin
      load_use_c     = 1'b0;
      md_hazard_c    = 1'b0;
      stall_c        = 1'b0;
      pc_write_c     = 1'b1;
      ifid_write_c   = 1'b1;
      idex_bubble_c  = 1'b0;
      ifid_flush_c   = 1'b0;
      md_start_c     = 1'b0;
      state_d        = state_q;
      md_cnt_d       = md_cnt_q;
      stall_cycles_d = stall_cycles_q;

      // A store's rt only supplies data, which mem-to-mem forwarding covers
      load_use_c = ps.IDEX_MemRead && (ps.IDEX_RegisterRt != 5'd0) &&
                   ((ps.IDEX_RegisterRt == ps.IFID_RegisterRs) ||
                    ((ps.IDEX_RegisterRt == ps.IFID_RegisterRt) && !ps.IFID_MemWrite));
      md_hazard_c = (state_q == MD_BUSY) && (ps.IFID_IsMulDiv || ps.IFID_UsesHiLo);

      if (!reset) begin
         stall_c = (load_use_c || md_hazard_c) && !ps.EX_BranchTaken;
         if (ps.EX_BranchTaken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
         end else if (stall_c) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
         end
         md_start_c = (state_q == RUN) && ps.IFID_IsMulDiv && !stall_c && !ps.EX_BranchTaken;
      end

      if (stall_c && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + SC_W'(1);
      end

      // A flush never cancels an issued mult/div: it is older than the branch
      unique case (state_q)
         RUN: begin
            if (md_start_c) begin
               state_d  = MD_BUSY;
               md_cnt_d = CNT_W'(MD_CYCLES);
            end
         end
         MD_BUSY: begin
            if (md_cnt_q <= CNT_W'(1)) begin
               state_d  = RUN;
               md_cnt_d = '0;
            end else begin
               md_cnt_d = md_cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d  = RUN;
            md_cnt_d = '0;
         end
      endcase
   end

   assign md_busy_c = (state_q == MD_BUSY) && !reset;

   assign ps.PCWrite      = pc_write_c;
   assign ps.IFID_Write   = ifid_write_c;
   assign ps.IDEX_Bubble  = idex_bubble_c;
   assign ps.IFID_Flush   = ifid_flush_c;
   assign ps.md_start     = md_start_c;
   assign ps.md_busy      = md_busy_c;
   assign ps.stall_cycles = stall_cycles_q;

endmodule
